rr_arb: RTL and testbench

RR_ARB -- requirements
Module: rr_arb

---
 rtl/rr_arb.sv | 107 ++++++++++
 tb/tb_rr_arb.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Purpose  : Round-robin arbiter with hold-until-release grants. In IDLE it
//            picks the first active requester searching circularly from the
//            priority pointer p. The grant is then held in BUSY until the
//            holder strobes done. The pointer then moves one past the
//            released index, so that requester has lowest priority next time.
// Ports    : clk   - single clock, rising edge
//            rst_n - asynchronous active-low reset
//            r     - [n-1:0] request vector
//            done  - release strobe from the current grant holder
//            g     - [n-1:0] registered one-hot grant (zero when idle)
//            gi    - [lg-1:0] registered index of the granted requester
//            v     - registered grant-valid flag
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb #(
   parameter int n  = 4,
   parameter int lg = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [n-1:0]  r,
   input  logic          done,
   output logic [n-1:0]  g,
   output logic [lg-1:0] gi,
   output logic          v
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   // n and n-1 in the widths used by the pointer arithmetic.
   localparam logic [lg:0]   N_EXT = (lg+1)'(n);
   localparam logic [lg-1:0] LAST  = lg'(n-1);

   logic [0:0]    state;
   logic [lg-1:0] p;

   logic          found;
   logic [lg-1:0] sel_idx;
   logic [n-1:0]  sel_onehot;
   logic [lg-1:0] p_next;
   logic [lg:0]   sum;

   // Circular first-set search starting at p. The candidate index p+k is
   // formed one bit wider and folded back at n. This keeps indices below n
   // even when n is not a power of two.
   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      sum     = '0;
      for (int k = 0; k < n; k++) begin
         sum = {1'b0, p} + k[lg:0];
         if (sum >= N_EXT) begin
            sum = sum - N_EXT;
         end
         if (!found && r[sum[lg-1:0]]) begin
            found   = 1'b1;
            sel_idx = sum[lg-1:0];
         end
      end
   end

   assign sel_onehot = {{(n-1){1'b0}}, 1'b1} << sel_idx;

   // Wrap at n rather than at 2^lg.
   assign p_next = (gi == LAST) ? '0 : gi + lg'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         p     <= '0;
         g     <= '0;
         gi    <= '0;
         v     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // done has no meaning without a grant, so it is ignored here.
               if (found) begin
                  g     <= sel_onehot;
                  gi    <= sel_idx;
                  v     <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               // Grant is held regardless of r; only done releases it.
               if (done) begin
                  g     <= '0;
                  gi    <= '0;
                  v     <= 1'b0;
                  p     <= p_next;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb
// Purpose  : Directed self-checking bench for rr_arb (n=4, lg=2). Expected
//            values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb;

   logic       clk;
   logic       rst_n;
   logic [3:0] r;
   logic       done;
   logic [3:0] g;
   logic [1:0] gi;
   logic       v;

   int checks   = 0;
   int failures = 0;

   rr_arb #(.n(4), .lg(2)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .r    (r),
      .done (done),
      .g    (g),
      .gi   (gi),
      .v    (v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_grant(input string tag, input logic [3:0] eg,
                              input logic [1:0] egi, input logic ev);
      check({tag, ".g"},  {28'd0, g},  {28'd0, eg});
      check({tag, ".gi"}, {30'd0, gi}, {30'd0, egi});
      check({tag, ".v"},  {31'd0, v},  {31'd0, ev});
   endtask

   logic [1:0] order [5];

   initial begin
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
      order[3] = 2'd3; order[4] = 2'd0;

      rst_n = 1'b0;
      r     = 4'b0000;
      done  = 1'b0;
      tick();
      tick();
      check_grant("reset", 4'b0000, 2'd0, 1'b0);
      check("reset.p", {30'd0, dut.p}, 32'd0);

      // Basic grant and release.
      rst_n = 1'b1;
      tick();
      check_grant("idle_after_reset", 4'b0000, 2'd0, 1'b0);
      r = 4'b1010;
      tick();
      check_grant("first_grant", 4'b0010, 2'd1, 1'b1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check_grant("release1", 4'b0000, 2'd0, 1'b0);
      check("release1.p", {30'd0, dut.p}, 32'd2);

      // Circular wrap of the search from p=2.
      r = 4'b0011;
      tick();
      check_grant("wrap_search", 4'b0001, 2'd0, 1'b1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("release2.p", {30'd0, dut.p}, 32'd1);

      // Fairness: all requesting, done held high so each BUSY cycle releases
      // and each IDLE cycle (where done is ignored) arbitrates.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      r    = 4'b1111;
      done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_grant($sformatf("rr%0d", i), 4'b0001 << order[i], order[i], 1'b1);
         tick();
         check($sformatf("rr%0d.bubble", i), {31'd0, v}, 32'd0);
      end
      check("rr.p", {30'd0, dut.p}, 32'd1);

      // done in IDLE with no requests: nothing changes.
      r = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("idle_done%0d.v", i), {31'd0, v}, 32'd0);
      end
      check("idle_done.p", {30'd0, dut.p}, 32'd1);
      done = 1'b0;

      // Grant held while r changes.
      r = 4'b0100;
      tick();
      check_grant("hold_grant", 4'b0100, 2'd2, 1'b1);
      r = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_grant($sformatf("hold%0d", i), 4'b0100, 2'd2, 1'b1);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      check("hold_release.p", {30'd0, dut.p}, 32'd3);

      // Release of index n-1 wraps pointer to 0.
      r = 4'b1001;
      tick();
      check_grant("grant3", 4'b1000, 2'd3, 1'b1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check("wrap_p", {30'd0, dut.p}, 32'd0);

      // Asynchronous reset while BUSY.
      r = 4'b1000;
      tick();
      check_grant("pre_reset_busy", 4'b1000, 2'd3, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check_grant("async_reset", 4'b0000, 2'd0, 1'b0);
      check("async_reset.p", {30'd0, dut.p}, 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      check_grant("post_reset_grant", 4'b1000, 2'd3, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
